// File: rtl/sha_round_sequencer_pkg.sv
// Shared definitions for the SHA-256 round sequencer.
//   state_t      : sequencer FSM encoding (also exported on the debug port)
//   LAST_ROUND   : index of the final compression round
//   SHA256_IV    : initial hash value used for the second pass, A in [255:224]
//   K_TABLE      : SHA-256 round constants K[0..63]
//   pass2_block  : pads a 256-bit digest into the single 512-bit block hashed
//                  by the second pass of a double SHA-256
package sha_round_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_ROUND = 6'd63;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // A 32-byte message fits one block: digest, the 0x80 terminator byte,
  // zero fill, and the 64-bit length field (256 bits = 0x100).
  function automatic logic [511:0] pass2_block(input logic [255:0] digest);
    return {digest, 32'h80000000, 192'h0, 32'h00000100};
  endfunction

endpackage

// File: rtl/sha_round_sequencer_if.sv
// Job / result handshake between the job dispatcher (master) and the
// round sequencer (slave).
//   in_valid/in_ready/in_m/in_h0/in_double : job channel
//   out_valid/out_ready/out_hash           : digest channel
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid & ready are both high. The producer holds valid and its payload
// stable until that edge; ready may depend on state but never on valid.
interface sha_round_sequencer_if;
  import sha_round_sequencer_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_m;
  logic [255:0] in_h0;
  logic         in_double;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_hash;

  modport master (
    output in_valid, in_m, in_h0, in_double, out_ready,
    input  in_ready, out_valid, out_hash
  );

  modport slave (
    input  in_valid, in_m, in_h0, in_double, out_ready,
    output in_ready, out_valid, out_hash
  );

endinterface

// File: rtl/sha_round_sequencer_k_rom.sv
// SHA-256 round-constant ROM.
//   addr : round index 0..63
//   k    : K[addr], combinational; the sequencer registers it
module sha_round_sequencer_k_rom
  import sha_round_sequencer_pkg::*;
(
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  assign k = K_TABLE[addr];

endmodule

// File: rtl/sha_round_sequencer.sv
// Sequences one sha_unit datapath through 64-round SHA-256 compressions,
// optionally chaining a second pass over the digest (double SHA-256).
//   clk, reset : clock, asynchronous active-high reset
//   job        : job/digest handshakes (slave side)
//   busy       : sequencer is not idle
//   su_round   : round index to the sha_unit
//   su_kt      : registered K constant, lags su_round by one round
//   su_m, su_h0: message block and chaining state held for the sha_unit
//   su_h1      : sha_unit digest, combinational, valid in FINAL
//   dbg_state  : current FSM state
module sha_round_sequencer
  import sha_round_sequencer_pkg::*;
#(
  parameter bit ENABLE_DOUBLE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  sha_round_sequencer_if.slave   job,
  output logic                   busy,
  output logic [5:0]             su_round,
  output logic [31:0]            su_kt,
  output logic [511:0]           su_m,
  output logic [255:0]           su_h0,
  input  logic [255:0]           su_h1,
  output state_t                 dbg_state
);

  state_t        state;
  state_t        state_next;
  logic          pass;      // 0: first pass, 1: second pass of a double job
  logic          dbl;       // current job wants a second pass
  logic          out_valid_q;
  logic [255:0]  out_hash_q;
  logic [31:0]   k_rom;
  logic          start_pass2;

  sha_round_sequencer_k_rom u_k_rom (
    .addr (su_round),
    .k    (k_rom)
  );

  assign start_pass2   = !pass && dbl;
  assign job.in_ready  = (state == S_IDLE);
  assign job.out_valid = out_valid_q;
  assign job.out_hash  = out_hash_q;
  assign busy          = (state != S_IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (job.in_valid) state_next = S_ROUND;
      S_ROUND: if (su_round == LAST_ROUND) state_next = S_FINAL;
      S_FINAL: state_next = start_pass2 ? S_ROUND : S_HOLD;
      S_HOLD:  if (job.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass        <= 1'b0;
      dbl         <= 1'b0;
      su_round    <= 6'd0;
      su_kt       <= 32'd0;
      su_m        <= 512'd0;
      su_h0       <= 256'd0;
      out_valid_q <= 1'b0;
      out_hash_q  <= 256'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job.in_valid) begin
            su_m     <= job.in_m;
            su_h0    <= job.in_h0;
            dbl      <= job.in_double & ENABLE_DOUBLE;
            pass     <= 1'b0;
            su_round <= 6'd0;
          end
        end
        S_ROUND: begin
          // K is registered so that su_kt == K[r-1] while su_round == r,
          // lining up with the sha_unit's one-cycle Wt pipeline.
          su_kt <= k_rom;
          if (su_round == LAST_ROUND) begin
            su_round <= 6'd0;
          end else begin
            su_round <= su_round + 6'd1;
          end
        end
        S_FINAL: begin
          if (start_pass2) begin
            su_m     <= pass2_block(su_h1);
            su_h0    <= SHA256_IV;
            pass     <= 1'b1;
            su_round <= 6'd0;
          end else begin
            out_hash_q  <= su_h1;
            out_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (job.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
